// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS program-counter sequencer.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } pc_seq_state_t;

  localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] PC_INCR         = 32'd4;

  // J-type targets keep the region bits of the delay-slot address.
  function automatic logic [31:0] jump_target(input logic [31:0] slot_addr,
                                              input logic [31:0] target);
    return {slot_addr[31:28], target[27:0]};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory read port with wait-request handshake.
interface pc_sequencer_if;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  modport master (output mem_read, output mem_address,
                  input  mem_waitrequest, input mem_readdata);
  modport slave  (input  mem_read, input mem_address,
                  output mem_waitrequest, output mem_readdata);
endinterface

// File: rtl/delay_slot_tracker.sv
// Holds the pending control-transfer target for the single architectural
// delay slot and produces the pc to load when an instruction retires.
module delay_slot_tracker
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        retire,
  input  logic        branch_taken,
  input  logic        branch_is_jump,
  input  logic [31:0] branch_target,
  input  logic [31:0] pc,
  output logic [31:0] next_pc
);

  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] pc_incr;

  // Capture a target only outside a delay slot; a branch in the slot is dropped.
  always_comb begin
    pc_incr       = pc + PC_INCR;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (retire) begin
      if (pend_valid_q) begin
        pend_valid_d = 1'b0;
      end else if (branch_taken) begin
        pend_valid_d  = 1'b1;
        pend_target_d = branch_is_jump ? jump_target(pc_incr, branch_target)
                                       : branch_target;
      end else begin
        pend_valid_d = 1'b0;
      end
    end else begin
      pend_valid_d = pend_valid_q;
    end
    next_pc = pend_valid_q ? pend_target_q : pc_incr;
  end

  // Pending-target registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'd0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute controller owning the program counter.
// Optional alignment trap: define PC_SEQ_ALIGN_CHECK_EN to add addr_error.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR
) (
  input  logic                 clk,
  input  logic                 reset,
  pc_sequencer_if.master       mem,
  input  logic                 ex_done,
  input  logic                 branch_taken,
  input  logic                 branch_is_jump,
  input  logic [31:0]          branch_target,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic [31:0]          pc,
`ifdef PC_SEQ_ALIGN_CHECK_EN
  output logic                 addr_error,
`endif
  output logic                 active
);

  pc_seq_state_t state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          mem_read_q, mem_read_d;
  logic          instr_valid_q, instr_valid_d;
  logic          active_q, active_d;
  logic          retire;
  logic [31:0]   next_pc;
`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic          addr_error_q, addr_error_d;
`endif

  assign retire = (state_q == ST_EXEC) && ex_done;

  delay_slot_tracker u_slot (
    .clk            (clk),
    .reset          (reset),
    .retire         (retire),
    .branch_taken   (branch_taken),
    .branch_is_jump (branch_is_jump),
    .branch_target  (branch_target),
    .pc             (pc_q),
    .next_pc        (next_pc)
  );

  // Next-state logic; outputs are registered from the decoded next state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    addr_error_d = addr_error_q;
`endif
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (!mem.mem_waitrequest) begin
          instr_d = mem.mem_readdata;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (ex_done) begin
          pc_d = next_pc;
          if (next_pc == 32'd0) begin
            state_d = ST_HALT;
`ifdef PC_SEQ_ALIGN_CHECK_EN
          end else if (is_misaligned(next_pc)) begin
            state_d      = ST_HALT;
            addr_error_d = 1'b1;
`endif
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
    mem_read_d    = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_EXEC);
    active_d      = (state_d == ST_FETCH) || (state_d == ST_EXEC);
  end

  // State, pc, instruction latch and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      instr_q       <= 32'd0;
      mem_read_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      active_q      <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      addr_error_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      mem_read_q    <= mem_read_d;
      instr_valid_q <= instr_valid_d;
      active_q      <= active_d;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      addr_error_q  <= addr_error_d;
`endif
    end
  end

  assign mem.mem_read    = mem_read_q;
  assign mem.mem_address = pc_q;
  assign instr           = instr_q;
  assign instr_valid     = instr_valid_q;
  assign pc              = pc_q;
  assign active          = active_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign addr_error      = addr_error_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; memory returns address ^ KEY.
module tb_pc_sequencer;
  import mips_pkg::*;

  localparam logic [31:0] KEY = 32'h5A5A_A5A5;

  logic        clk;
  logic        reset;
  logic        ex_done;
  logic        branch_taken;
  logic        branch_is_jump;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        active;
`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic        addr_error;
`endif
  int          n_checks;
  int          n_fail;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .mem            (bus),
    .ex_done        (ex_done),
    .branch_taken   (branch_taken),
    .branch_is_jump (branch_is_jump),
    .branch_target  (branch_target),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .pc             (pc),
`ifdef PC_SEQ_ALIGN_CHECK_EN
    .addr_error     (addr_error),
`endif
    .active         (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b0; ex_done = 1'b0; branch_taken = 1'b0; branch_is_jump = 1'b0;
    branch_target = 32'd0; bus.mem_waitrequest = 1'b0; bus.mem_readdata = 32'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs one fetch (with waits) plus one retire; starts and ends just after an edge.
  task automatic do_instr(input int waits, input logic br, input logic jmp,
                          input logic [31:0] tgt, input logic exd_in_fetch,
                          output logic [31:0] f_addr, output logic stable,
                          output logic [31:0] got_instr, output logic got_valid);
    f_addr = bus.mem_address;
    stable = bus.mem_read;
    bus.mem_readdata = f_addr ^ KEY;
    bus.mem_waitrequest = (waits > 0);
    ex_done = exd_in_fetch;
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
      if (!bus.mem_read || bus.mem_address !== f_addr || instr_valid) stable = 1'b0;
    end
    bus.mem_waitrequest = 1'b0;
    ex_done = 1'b0;
    @(posedge clk); #1;
    got_instr = instr;
    got_valid = instr_valid & ~bus.mem_read;
    bus.mem_readdata = 32'hDEAD_BEEF;
    ex_done = 1'b1; branch_taken = br; branch_is_jump = jmp; branch_target = tgt;
    @(posedge clk); #1;
    ex_done = 1'b0; branch_taken = 1'b0; branch_is_jump = 1'b0; branch_target = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0; ex_done = 1'b0; branch_taken = 1'b0; branch_is_jump = 1'b0;
    branch_target = 32'd0; bus.mem_waitrequest = 1'b0; bus.mem_readdata = 32'd0;
    #12;
    n_checks++;
    if ({pc, instr} !== {32'hBFC0_0000, 32'd0}) begin
      n_fail++; $display("FAIL reset_pc_instr: got %h %h expected bfc00000 00000000", pc, instr);
    end
    n_checks++;
    if ({bus.mem_read, instr_valid, active} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.mem_read, instr_valid, active});
    end
`ifdef PC_SEQ_ALIGN_CHECK_EN
    n_checks++;
    if (addr_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_addr_error: got %b expected 0", addr_error);
    end
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.mem_read, active, instr_valid, bus.mem_address} !== {3'b110, 32'hBFC0_0000}) begin
      n_fail++; $display("FAIL boot_to_fetch: got %b %h expected 110 bfc00000",
                         {bus.mem_read, active, instr_valid}, bus.mem_address);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] f, gi, exp_a;
    logic st, gv;
    for (int i = 0; i < 3; i++) begin
      exp_a = 32'hBFC0_0000 + 32'(i * 4);
      do_instr(0, 1'b0, 1'b0, 32'd0, 1'b0, f, st, gi, gv);
      n_checks++;
      if (f !== exp_a || st !== 1'b1) begin
        n_fail++; $display("FAIL seq_addr[%0d]: got %h/%b expected %h/1", i, f, st, exp_a);
      end
      n_checks++;
      if (gi !== (exp_a ^ KEY) || gv !== 1'b1) begin
        n_fail++; $display("FAIL seq_instr[%0d]: got %h/%b expected %h/1", i, gi, gv, exp_a ^ KEY);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] f, gi;
    logic st, gv;
    do_instr(3, 1'b0, 1'b0, 32'd0, 1'b1, f, st, gi, gv);
    n_checks++;
    if (f !== 32'hBFC0_000C || st !== 1'b1) begin
      n_fail++; $display("FAIL wait_stable: got %h/%b expected bfc0000c/1", f, st);
    end
    n_checks++;
    if (gi !== (32'hBFC0_000C ^ KEY)) begin
      n_fail++; $display("FAIL wait_instr: got %h expected %h", gi, 32'hBFC0_000C ^ KEY);
    end
    n_checks++;
    if (pc !== 32'hBFC0_0010) begin
      n_fail++; $display("FAIL wait_exdone_ignored: got %h expected bfc00010", pc);
    end
  endtask

  task automatic test_branch();
    logic [31:0] f, gi;
    logic st, gv;
    apply_reset();
    do_instr(0, 1'b1, 1'b0, 32'hBFC0_0100, 1'b0, f, st, gi, gv);
    n_checks++;
    if (f !== 32'hBFC0_0000) begin
      n_fail++; $display("FAIL br_first: got %h expected bfc00000", f);
    end
    do_instr(0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, f, st, gi, gv);
    n_checks++;
    if (f !== 32'hBFC0_0004) begin
      n_fail++; $display("FAIL br_slot: got %h expected bfc00004", f);
    end
    do_instr(0, 1'b0, 1'b0, 32'd0, 1'b0, f, st, gi, gv);
    n_checks++;
    if (f !== 32'hBFC0_0100 || gi !== (32'hBFC0_0100 ^ KEY)) begin
      n_fail++; $display("FAIL br_target: got %h/%h expected bfc00100", f, gi);
    end
    n_checks++;
    if (bus.mem_address !== 32'hBFC0_0104 || bus.mem_read !== 1'b1) begin
      n_fail++; $display("FAIL br_after: got %h/%b expected bfc00104/1", bus.mem_address, bus.mem_read);
    end
  endtask

  task automatic test_jump();
    logic [31:0] f, gi;
    logic st, gv;
    apply_reset();
    for (int i = 0; i < 4; i++) do_instr(0, 1'b0, 1'b0, 32'd0, 1'b0, f, st, gi, gv);
    do_instr(0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, f, st, gi, gv);
    n_checks++;
    if (f !== 32'hBFC0_0010) begin
      n_fail++; $display("FAIL jmp_site: got %h expected bfc00010", f);
    end
    do_instr(0, 1'b0, 1'b0, 32'd0, 1'b0, f, st, gi, gv);
    n_checks++;
    if (f !== 32'hBFC0_0014 || pc !== 32'hB000_0040 || bus.mem_read !== 1'b1) begin
      n_fail++; $display("FAIL jmp_target: got %h/%h/%b expected bfc00014/b0000040/1", f, pc, bus.mem_read);
    end
  endtask

  task automatic test_halt();
    logic [31:0] f, gi;
    logic st, gv;
    apply_reset();
    do_instr(0, 1'b1, 1'b0, 32'd0, 1'b0, f, st, gi, gv);
    n_checks++;
    if (active !== 1'b1 || bus.mem_address !== 32'hBFC0_0004) begin
      n_fail++; $display("FAIL halt_slot_fetch: got %b/%h expected 1/bfc00004", active, bus.mem_address);
    end
    do_instr(0, 1'b0, 1'b0, 32'd0, 1'b0, f, st, gi, gv);
    n_checks++;
    if ({active, bus.mem_read, instr_valid, pc} !== {3'b000, 32'd0}) begin
      n_fail++; $display("FAIL halt_entry: got %b %h expected 000 00000000",
                         {active, bus.mem_read, instr_valid}, pc);
    end
    ex_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({active, bus.mem_read, pc} !== {2'b00, 32'd0}) begin
        n_fail++; $display("FAIL halt_stays[%0d]: got %b %h expected 00 00000000",
                           i, {active, bus.mem_read}, pc);
      end
    end
    ex_done = 1'b0;
    reset = 1'b0;
    #2;
    n_checks++;
    if ({pc, active, bus.mem_read} !== {32'hBFC0_0000, 2'b00}) begin
      n_fail++; $display("FAIL halt_reset: got %h %b expected bfc00000 00", pc, {active, bus.mem_read});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({active, bus.mem_read, bus.mem_address} !== {2'b11, 32'hBFC0_0000}) begin
      n_fail++; $display("FAIL halt_restart: got %b %h expected 11 bfc00000",
                         {active, bus.mem_read}, bus.mem_address);
    end
  endtask

  task automatic test_reset_mid_read();
    bus.mem_waitrequest = 1'b1;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_read, active} !== 2'b00) begin
      n_fail++; $display("FAIL mid_read_reset: got %b expected 00", {bus.mem_read, active});
    end
    apply_reset();
  endtask

  task automatic test_wrap();
    logic [31:0] f, gi;
    logic st, gv;
    apply_reset();
    do_instr(0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, f, st, gi, gv);
    do_instr(0, 1'b0, 1'b0, 32'd0, 1'b0, f, st, gi, gv);
    do_instr(0, 1'b0, 1'b0, 32'd0, 1'b0, f, st, gi, gv);
    n_checks++;
    if (f !== 32'hFFFF_FFFC || gi !== (32'hFFFF_FFFC ^ KEY)) begin
      n_fail++; $display("FAIL wrap_fetch: got %h/%h expected fffffffc", f, gi);
    end
    n_checks++;
    if ({pc, active, bus.mem_read} !== {32'd0, 2'b00}) begin
      n_fail++; $display("FAIL wrap_halt: got %h %b expected 00000000 00", pc, {active, bus.mem_read});
    end
  endtask

  task automatic test_align();
    logic [31:0] f, gi;
    logic st, gv;
    apply_reset();
    do_instr(0, 1'b1, 1'b0, 32'hBFC0_0102, 1'b0, f, st, gi, gv);
    do_instr(0, 1'b0, 1'b0, 32'd0, 1'b0, f, st, gi, gv);
`ifdef PC_SEQ_ALIGN_CHECK_EN
    n_checks++;
    if ({addr_error, active, bus.mem_read, pc} !== {3'b100, 32'hBFC0_0102}) begin
      n_fail++; $display("FAIL align_trap: got %b %h expected 100 bfc00102",
                         {addr_error, active, bus.mem_read}, pc);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({addr_error, bus.mem_read} !== 2'b10) begin
      n_fail++; $display("FAIL align_hold: got %b expected 10", {addr_error, bus.mem_read});
    end
`else
    n_checks++;
    if ({active, bus.mem_read, bus.mem_address} !== {2'b11, 32'hBFC0_0102}) begin
      n_fail++; $display("FAIL align_fetch_as_is: got %b %h expected 11 bfc00102",
                         {active, bus.mem_read}, bus.mem_address);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_branch();
    test_jump();
    test_halt();
    test_reset_mid_read();
    test_wrap();
    test_align();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
